// File: rtl/rc5_pkg.sv
// Shared RC5-16 definitions for the key schedule and the round engine.
package rc5_pkg;

  localparam int MAX_ROUNDS    = 16;
  localparam int MAX_KEY_BYTES = 16;
  localparam int NUM_SUBKEYS   = 2 * MAX_ROUNDS + 2;
  localparam int KEY_WORDS     = MAX_KEY_BYTES / 2;

  typedef logic [15:0] word_t;

  localparam word_t P16 = 16'hB7E1;
  localparam word_t Q16 = 16'h9E37;

  typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;

endpackage

// File: rtl/rc5_key_expand_rotl.sv
// 16-bit rotate-left by a 0..15 amount, used for both key-mix rotations.
module rc5_key_expand_rotl
  import rc5_pkg::*;
(
  input  word_t      data,
  input  logic [3:0] amount,
  output word_t      result
);

  logic [31:0] doubled;
  logic [31:0] shifted;

  // Rotating left by s equals the low half of {d,d} shifted right by 16-s.
  always_comb begin
    doubled = {data, data};
    shifted = doubled >> (5'd16 - {1'b0, amount});
    result  = shifted[15:0];
  end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-16 key schedule: expands up to 16 key bytes into the S table, one mix step per clock.
module rc5_key_expand
  import rc5_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   num_rounds,
  input  logic [127:0] key,
  input  logic [4:0]   key_len,
  output word_t        subkeys [0:NUM_SUBKEYS-1],
  output logic         busy,
  output logic         ready
);

  state_t     state;
  word_t      l_words [0:KEY_WORDS-1];
  word_t      a_reg;
  word_t      b_reg;
  logic [5:0] t_reg;
  logic [3:0] c_reg;
  logic [6:0] n_reg;
  logic [5:0] idx;
  logic [5:0] i_idx;
  logic [2:0] j_idx;
  logic [6:0] iter;

  logic [4:0] r_cl;
  logic [4:0] b_cl;
  logic [5:0] t_next;
  logic [3:0] c_next;
  logic [5:0] tc_max;
  logic [6:0] n_next;
  logic [7:0] key_bytes [0:MAX_KEY_BYTES-1];
  word_t      l_next [0:KEY_WORDS-1];

  // Derived schedule sizes and the masked little-endian L array, used only on an accepting edge.
  always_comb begin
    r_cl   = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds;
    b_cl   = (key_len > 5'(MAX_KEY_BYTES)) ? 5'(MAX_KEY_BYTES) : key_len;
    t_next = {r_cl, 1'b0} + 6'd2;
    c_next = (b_cl == 5'd0) ? 4'd1 : 4'((b_cl + 5'd1) >> 1);
    tc_max = (t_next >= {2'b00, c_next}) ? t_next : {2'b00, c_next};
    n_next = 7'd3 * {1'b0, tc_max};
    for (int k = 0; k < MAX_KEY_BYTES; k++) begin
      key_bytes[k] = (5'(k) < b_cl) ? key[8*k +: 8] : 8'h00;
    end
    for (int w = 0; w < KEY_WORDS; w++) begin
      l_next[w] = {key_bytes[2*w+1], key_bytes[2*w]};
    end
  end

  word_t sum_a;
  word_t a_new;
  word_t ab_sum;
  word_t sum_b;
  word_t b_new;

  always_comb begin
    sum_a  = subkeys[i_idx] + a_reg + b_reg;
    ab_sum = a_new + b_reg;
    sum_b  = l_words[j_idx] + ab_sum;
  end

  rc5_key_expand_rotl u_rot_a (
    .data   (sum_a),
    .amount (4'd3),
    .result (a_new)
  );

  rc5_key_expand_rotl u_rot_b (
    .data   (sum_b),
    .amount (ab_sum[3:0]),
    .result (b_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      t_reg <= '0;
      c_reg <= '0;
      n_reg <= '0;
      idx   <= '0;
      i_idx <= '0;
      j_idx <= '0;
      iter  <= '0;
      for (int s = 0; s < NUM_SUBKEYS; s++) subkeys[s] <= '0;
      for (int w = 0; w < KEY_WORDS; w++) l_words[w] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            t_reg <= t_next;
            c_reg <= c_next;
            n_reg <= n_next;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            for (int s = 0; s < NUM_SUBKEYS; s++) subkeys[s] <= '0;
            for (int w = 0; w < KEY_WORDS; w++) l_words[w] <= l_next[w];
            state <= INIT;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        INIT: begin
          subkeys[idx] <= P16 + Q16 * {10'b0, idx};
          if (idx == t_reg - 6'd1) begin
            i_idx <= '0;
            j_idx <= '0;
            iter  <= '0;
            state <= MIX;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        MIX: begin
          subkeys[i_idx] <= a_new;
          l_words[j_idx] <= b_new;
          a_reg <= a_new;
          b_reg <= b_new;
          i_idx <= (i_idx == t_reg - 6'd1) ? 6'd0 : i_idx + 6'd1;
          j_idx <= ({1'b0, j_idx} == c_reg - 4'd1) ? 3'd0 : j_idx + 3'd1;
          if (iter == n_reg - 7'd1) begin
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            iter <= iter + 7'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Randomized self-checking bench for rc5_key_expand against an arithmetic RC5-16 key-schedule model.
module tb_rc5_key_expand;
  import rc5_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [4:0]   num_rounds;
  logic [127:0] key;
  logic [4:0]   key_len;
  word_t        subkeys [0:NUM_SUBKEYS-1];
  logic         busy;
  logic         ready;

  int    check_count = 0;
  int    error_count = 0;
  word_t exp_s [0:NUM_SUBKEYS-1];
  int    exp_lat;

  always #5 clk = ~clk;

  rc5_key_expand dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_rounds (num_rounds),
    .key        (key),
    .key_len    (key_len),
    .subkeys    (subkeys),
    .busy       (busy),
    .ready      (ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int rotl16(input int x, input int s);
    return ((x << s) | (x >> (16 - s))) & 32'hFFFF;
  endfunction

  // Straight transcription of the RC5 key schedule with clamping, giving the table and latency.
  task automatic computeModel(input logic [127:0] k, input int kl, input int nr);
    int r, t, b, c, n, a, bb, i, j;
    int s [0:NUM_SUBKEYS-1];
    int lw [0:KEY_WORDS-1];
    r = (nr > MAX_ROUNDS) ? MAX_ROUNDS : nr;
    b = (kl > MAX_KEY_BYTES) ? MAX_KEY_BYTES : kl;
    t = 2 * (r + 1);
    c = (b == 0) ? 1 : (b + 1) / 2;
    n = 3 * ((t > c) ? t : c);
    for (int w = 0; w < KEY_WORDS; w++) lw[w] = 0;
    for (int m = 0; m < b; m++) lw[m/2] = lw[m/2] | (int'(k[8*m +: 8]) << (8 * (m % 2)));
    for (int x = 0; x < NUM_SUBKEYS; x++) s[x] = (x < t) ? ((32'hB7E1 + x * 32'h9E37) & 32'hFFFF) : 0;
    a = 0; bb = 0; i = 0; j = 0;
    for (int it = 0; it < n; it++) begin
      a     = rotl16((s[i] + a + bb) & 32'hFFFF, 3);
      s[i]  = a;
      bb    = rotl16((lw[j] + a + bb) & 32'hFFFF, (a + bb) & 15);
      lw[j] = bb;
      i     = (i + 1) % t;
      j     = (j + 1) % c;
    end
    for (int x = 0; x < NUM_SUBKEYS; x++) exp_s[x] = 16'(s[x]);
    exp_lat = t + n;
  endtask

  task automatic checkTable(input string tag);
    for (int x = 0; x < NUM_SUBKEYS; x++) begin
      checkOutput($sformatf("%s_s%0d", tag, x), 32'(subkeys[x]), 32'(exp_s[x]));
    end
  endtask

  task automatic checkCleared(input string tag);
    logic [15:0] any_bits;
    any_bits = '0;
    for (int x = 0; x < NUM_SUBKEYS; x++) any_bits = any_bits | subkeys[x];
    checkOutput({tag, "_subkeys"}, 32'(any_bits), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_ready"}, 32'(ready), 32'h0);
  endtask

  // Issues one start pulse, then scrambles the inputs to show they are only used at acceptance.
  task automatic startOp(input logic [127:0] k, input logic [4:0] kl, input logic [4:0] nr, input string tag);
    @(negedge clk);
    key = k; key_len = kl; num_rounds = nr; start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_busy_on_accept"}, 32'(busy), 32'h1);
    checkOutput({tag, "_ready_on_accept"}, 32'(ready), 32'h0);
    @(negedge clk);
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    key_len = 5'($urandom_range(0, 31));
    num_rounds = 5'($urandom_range(0, 31));
  endtask

  task automatic waitReady(input int lat0, output int lat);
    lat = lat0;
    while (!ready && lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [127:0] k, input logic [4:0] kl, input logic [4:0] nr, input string tag);
    int lat;
    computeModel(k, int'(kl), int'(nr));
    startOp(k, kl, nr, tag);
    waitReady(0, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'h0);
    checkTable(tag);
  endtask

  initial begin
    logic [127:0] k1;
    int lat;
    rst_n = 1'b0; start = 1'b0; key = '0; key_len = '0; num_rounds = '0;
    #12;
    checkCleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(128'h0, 5'd0, 5'd0, "zero");
    applyStimulus(128'h0F0E0D0C0B0A09080706050403020100, 5'd16, 5'd12, "full");

    k1 = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(k1, 5'd31, 5'd20, "clamp");
    computeModel(k1, 16, 16);
    checkTable("clamp_eq");

    for (int n = 0; n < 6; n++) begin
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), $sformatf("rand%0d", n));
    end

    // DONE holds its table while start stays low, then a new start restarts cleanly.
    repeat (5) @(posedge clk);
    #1;
    checkOutput("hold_ready", 32'(ready), 32'h1);
    checkTable("hold");
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 5'd9, 5'd7, "b2b");

    k1 = {$urandom, $urandom, $urandom, $urandom};
    computeModel(k1, 16, 16);
    startOp(k1, 5'd16, 5'd16, "busy");
    lat = 0;
    repeat (50) begin
      @(posedge clk);
      lat++;
    end
    #1;
    checkOutput("busy_mid_mix", 32'(busy), 32'h1);
    @(negedge clk);
    key = ~k1; key_len = 5'd3; num_rounds = 5'd2; start = 1'b1;
    @(posedge clk);
    lat++;
    @(negedge clk);
    start = 1'b0;
    waitReady(lat, lat);
    checkOutput("busy_latency", 32'(lat), 32'(exp_lat));
    checkTable("busy");

    startOp({$urandom, $urandom, $urandom, $urandom}, 5'd16, 5'd16, "rinit");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkCleared("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkCleared("rst_init_idle");
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 5'd11, 5'd5, "after_rinit");

    startOp({$urandom, $urandom, $urandom, $urandom}, 5'd8, 5'd4, "rmix");
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkCleared("rst_mix");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 5'd16, 5'd16, "after_rmix");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rc5_key_expand.md
Name: rc5_key_expand

Overview:
RC5-16 key-schedule stage that sits directly upstream of the encrypt/decrypt round engine. It expands a secret key of up to 16 bytes into the subkey table S[0..2r+1]. Output format is 34 x 16-bit words, matching the round engine's subkeys input. One mix iteration runs per clock. The table is valid while ready=1 and is held until the next accepted start.

Parameters:
MAX_ROUNDS, 16, upper clamp on num_rounds; table depth is 2*MAX_ROUNDS+2 = 34.
MAX_KEY_BYTES, 16, key bus width in bytes; L array depth is MAX_KEY_BYTES/2 = 8 words.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request expansion; sampled only in IDLE or DONE.
num_rounds  in  5  round count r, not 0-indexed; values >MAX_ROUNDS clamp to MAX_ROUNDS.
key  in  128  secret key; byte k = key[8k+7:8k].
key_len  in  5  key length b in bytes, 0..16; values >16 clamp to 16.
subkeys  out  16 x [0:33]  expanded table S.
busy  out  1  high in INIT and MIX.
ready  out  1  high in DONE; table valid.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, ready=0, all subkeys=0, L=0, A=B=0, i=j=0.
- Derived values: t = 2*(r+1) with r clamped. c = max(1, ceil(b/2)). n = 3*max(t,c).
- L load: L[j] = {byte 2j+1, byte 2j}, little-endian. Bytes at index >= b are forced to 0.
- IDLE: on start=1, latch r, t, c, n, load L, clear all 34 subkeys, A=B=0, idx=0; go to INIT.
- DONE: start=1 behaves exactly as in IDLE. start=0 holds DONE.
- INIT: one write per cycle, S[idx] = P16 + idx*Q16 (mod 2^16). P16=0xB7E1, Q16=0x9E37.
  - Occupies t cycles.
  - After idx=t-1, go to MIX with i=j=0 and an iteration counter of 0.
- MIX, one iteration per cycle, all sums mod 2^16:
  - A' = rotl(S[i]+A+B, 3); S[i] = A'.
  - B' = rotl(L[j]+A'+B, (A'+B)[3:0]); L[j] = B'.
  - A=A', B=B'.
  - i wraps at t-1 back to 0; j wraps at c-1 back to 0.
  - Occupies n cycles, then go to DONE.
- Latency: if start is sampled at edge E0, ready=1 after edge E0+t+n. Example: r=0, b=0 gives 8 edges; r=16, b=16 gives 136 edges.
- Table entries with index >= t remain 0.
- start while busy=1 is ignored: no restart and no latch update.
- key, key_len and num_rounds are used only at the accepting edge; later changes have no effect.
- subkeys contents during busy=1 are intermediate and not for consumer use.
- ready drops on the edge that accepts a new start.
- rst_n asserted mid-INIT or mid-MIX immediately returns to reset values; a new start is required afterwards.

Decomposition:
- Package rc5_pkg holds:
  - P16, Q16, NUM_SUBKEYS=34, MAX_ROUNDS;
  - the subkey word type (16-bit);
  - the state enum {IDLE, INIT, MIX, DONE}.
- The round engine imports the same package.
- Reuse the existing rotl sub-module for both rotations: fixed shift 3 and data-dependent (A'+B)[3:0].
- No new sub-module is required.

Test Plan:
- Zero key: key=0, key_len=0, num_rounds=0, start pulse -> busy for 8 cycles, then ready=1 with subkeys[0]=0x7865, subkeys[1]=0x33F4, and subkeys[2..33]=0.
- Full key: num_rounds=12, key_len=16, key=0x0F0E..0100, start -> ready exactly 104 edges after start; all 26 words match the C golden model; subkeys[26..33]=0.
- Clamping: num_rounds=20, key_len=31 -> identical timing (136 edges) and identical table to num_rounds=16, key_len=16.
- Busy protection: start pulsed again mid-MIX with a different key -> ignored; final table equals the first request's golden result; ready timing unchanged.
- Reset mid-operation: rst_n low for 1 cycle during INIT, and separately during MIX -> subkeys immediately 0, busy=0, ready=0; a following start completes correctly.
- Back-to-back operation: start asserted while in DONE with a new key -> ready falls on the next edge, and a new table is produced with correct latency; the table from DONE is held stable while start=0.
